// File: rtl/tmvp_operand_store_pkg.sv
// -----------------------------------------------------------------------------
// tmvp_operand_store_pkg
// Shared definitions for the TMVP2 operand store: the FSM state encoding,
// default geometry, and the nominal frame length (row + column + vector).
// -----------------------------------------------------------------------------
package tmvp_operand_store_pkg;

   typedef enum logic [2:0] {
      ST_LOAD_ROW = 3'd0,
      ST_LOAD_COL = 3'd1,
      ST_LOAD_VEC = 3'd2,
      ST_START    = 3'd3,
      ST_RUN      = 3'd4
   } state_e;

   localparam int DEF_N          = 32;
   localparam int DEF_DATA_WIDTH = 8;

   // One frame carries three N-word operands back to back.
   localparam int FRAME_LEN      = 3 * DEF_N;

endpackage

// File: rtl/tmvp_reg_bank.sv
// -----------------------------------------------------------------------------
// tmvp_reg_bank
// N x DATA_WIDTH register file with one write port and two independent
// registered read ports (one-cycle latency). A read port only updates its
// output register when its enable is high, so the output holds otherwise.
// Reading an address >= N returns 0.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset (clears read regs)
//   we_i, waddr_i,      write enable / address / data
//   wdata_i
//   re1_i, raddr1_i     read port 1 enable / address
//   re2_i, raddr2_i     read port 2 enable / address
//   rdata1_o, rdata2_o  registered read data
// -----------------------------------------------------------------------------
module tmvp_reg_bank
   import tmvp_operand_store_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re1_i,
   input  logic [ADDR_WIDTH-1:0] raddr1_i,
   input  logic                  re2_i,
   input  logic [ADDR_WIDTH-1:0] raddr2_i,
   output logic [DATA_WIDTH-1:0] rdata1_o,
   output logic [DATA_WIDTH-1:0] rdata2_o
);

   logic [DATA_WIDTH-1:0] mem_q [N];
   logic [DATA_WIDTH-1:0] rdata1_q;
   logic [DATA_WIDTH-1:0] rdata2_q;
   logic [DATA_WIDTH-1:0] rdata1_d;
   logic [DATA_WIDTH-1:0] rdata2_d;

   // Storage is deliberately not reset: contents are only meaningful after a
   // complete frame has been written.
   always_ff @(posedge clk) begin
      if (we_i && (int'(waddr_i) < N)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Out-of-range addresses read as zero.
   always_comb begin
      rdata1_d = '0;
      rdata2_d = '0;
      if (int'(raddr1_i) < N) rdata1_d = mem_q[raddr1_i];
      if (int'(raddr2_i) < N) rdata2_d = mem_q[raddr2_i];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rdata1_q <= '0;
         rdata2_q <= '0;
      end else begin
         if (re1_i) rdata1_q <= rdata1_d;
         if (re2_i) rdata2_q <= rdata2_d;
      end
   end

   assign rdata1_o = rdata1_q;
   assign rdata2_o = rdata2_q;

endmodule

// File: rtl/tmvp_operand_store.sv
// -----------------------------------------------------------------------------
// tmvp_operand_store
// Operand buffer in front of the TMVP2 Toeplitz matrix-vector core. Loads one
// frame (row[0..N-1], col[0..N-1], vec[0..N-1]) from a stream, pulses start,
// then serves TMVP2's row/column and vector reads with one-cycle latency until
// N result beats have been seen, after which it rearms for the next frame.
//
// Handshake: a load word transfers on a cycle where s_axis_tvalid and
// s_axis_tready are both high; tready is high in the three LOAD states only.
// Read requests have no backpressure: a request (valid high) in cycle t is
// answered with data and valid in cycle t+1, but only in START and RUN.
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast load stream
//   start                            one-cycle pulse to TMVP2
//   res_valid                        tap of TMVP2 result valid
//   address_1/2, address_*_isRow,    row/column read request
//   address_row_valid
//   data_row_data_1/2, data_row_valid row/column read response
//   address_vec_1/2, address_vec_valid vector read request
//   data_vec_data_1/2, data_vec_valid vector read response
//   busy                             high in START and RUN
//   load_error                       one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module tmvp_operand_store
   import tmvp_operand_store_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic                  start,
   input  logic                  res_valid,
   input  logic [ADDR_WIDTH-1:0] address_1,
   input  logic [ADDR_WIDTH-1:0] address_2,
   input  logic                  address_1_isRow,
   input  logic                  address_2_isRow,
   input  logic                  address_row_valid,
   output logic [DATA_WIDTH-1:0] data_row_data_1,
   output logic [DATA_WIDTH-1:0] data_row_data_2,
   output logic                  data_row_valid,
   input  logic [ADDR_WIDTH-1:0] address_vec_1,
   input  logic [ADDR_WIDTH-1:0] address_vec_2,
   input  logic                  address_vec_valid,
   output logic [DATA_WIDTH-1:0] data_vec_data_1,
   output logic [DATA_WIDTH-1:0] data_vec_data_2,
   output logic                  data_vec_valid,
   output logic                  busy,
   output logic                  load_error
);

   localparam int               CNT_W   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);
   // Index of the final frame word, scaled from the default geometry to N.
   localparam int               LAST_K  = (FRAME_LEN * N) / DEF_N - 1;

   state_e           state_q;
   logic [CNT_W-1:0] word_cnt_q;
   logic [CNT_W-1:0] res_cnt_q;
   logic             start_q;
   logic             busy_q;
   logic             load_error_q;
   logic             row_valid_q;
   logic             vec_valid_q;
   logic             is_row1_q;
   logic             is_row2_q;

   logic             load_state;
   logic             serving;
   logic             accept;
   logic             word_is_last;
   logic             frame_error;
   int               word_k;
   logic             row_re;
   logic             vec_re;
   logic             row_we;
   logic             col_we;
   logic             vec_we;
   logic [ADDR_WIDTH-1:0] wr_addr;

   logic [DATA_WIDTH-1:0] row_rd1, row_rd2;
   logic [DATA_WIDTH-1:0] col_rd1, col_rd2;

   // Frame-position decode: word_k is the index of the current word within
   // the whole frame, so tlast must coincide exactly with the final index.
   always_comb begin
      load_state = (state_q == ST_LOAD_ROW) || (state_q == ST_LOAD_COL) ||
                   (state_q == ST_LOAD_VEC);
      serving    = (state_q == ST_START) || (state_q == ST_RUN);
      accept     = s_axis_tvalid && load_state;
      case (state_q)
         ST_LOAD_COL: word_k = N + int'(word_cnt_q);
         ST_LOAD_VEC: word_k = 2 * N + int'(word_cnt_q);
         default:     word_k = int'(word_cnt_q);
      endcase
      word_is_last = (word_k == LAST_K);
      frame_error  = accept && (s_axis_tlast != word_is_last);
   end

   // The offending word of a framing error is never written.
   assign row_we  = accept && !frame_error && (state_q == ST_LOAD_ROW);
   assign col_we  = accept && !frame_error && (state_q == ST_LOAD_COL);
   assign vec_we  = accept && !frame_error && (state_q == ST_LOAD_VEC);
   assign wr_addr = ADDR_WIDTH'(word_cnt_q);

   assign row_re  = serving && address_row_valid;
   assign vec_re  = serving && address_vec_valid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_LOAD_ROW;
         word_cnt_q   <= '0;
         res_cnt_q    <= '0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         load_error_q <= 1'b0;
         row_valid_q  <= 1'b0;
         vec_valid_q  <= 1'b0;
         is_row1_q    <= 1'b0;
         is_row2_q    <= 1'b0;
      end else begin
         start_q      <= 1'b0;
         load_error_q <= 1'b0;
         row_valid_q  <= row_re;
         vec_valid_q  <= vec_re;
         // isRow travels with the address so the mux matches the bank output.
         if (row_re) begin
            is_row1_q <= address_1_isRow;
            is_row2_q <= address_2_isRow;
         end
         case (state_q)
            ST_LOAD_ROW, ST_LOAD_COL, ST_LOAD_VEC: begin
               if (accept) begin
                  if (frame_error) begin
                     state_q      <= ST_LOAD_ROW;
                     word_cnt_q   <= '0;
                     load_error_q <= 1'b1;
                  end else if (word_cnt_q == CNT_MAX) begin
                     word_cnt_q <= '0;
                     if (state_q == ST_LOAD_ROW) begin
                        state_q <= ST_LOAD_COL;
                     end else if (state_q == ST_LOAD_COL) begin
                        state_q <= ST_LOAD_VEC;
                     end else begin
                        state_q <= ST_START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                     end
                  end else begin
                     word_cnt_q <= word_cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_START: begin
               state_q   <= ST_RUN;
               res_cnt_q <= '0;
            end
            ST_RUN: begin
               if (res_valid) begin
                  if (res_cnt_q == CNT_MAX) begin
                     state_q   <= ST_LOAD_ROW;
                     busy_q    <= 1'b0;
                     res_cnt_q <= '0;
                  end else begin
                     res_cnt_q <= res_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_LOAD_ROW;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   tmvp_reg_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_row_bank (
      .clk      (clk),
      .reset    (reset),
      .we_i     (row_we),
      .waddr_i  (wr_addr),
      .wdata_i  (s_axis_tdata),
      .re1_i    (row_re),
      .raddr1_i (address_1),
      .re2_i    (row_re),
      .raddr2_i (address_2),
      .rdata1_o (row_rd1),
      .rdata2_o (row_rd2)
   );

   tmvp_reg_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_col_bank (
      .clk      (clk),
      .reset    (reset),
      .we_i     (col_we),
      .waddr_i  (wr_addr),
      .wdata_i  (s_axis_tdata),
      .re1_i    (row_re),
      .raddr1_i (address_1),
      .re2_i    (row_re),
      .raddr2_i (address_2),
      .rdata1_o (col_rd1),
      .rdata2_o (col_rd2)
   );

   tmvp_reg_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_vec_bank (
      .clk      (clk),
      .reset    (reset),
      .we_i     (vec_we),
      .waddr_i  (wr_addr),
      .wdata_i  (s_axis_tdata),
      .re1_i    (vec_re),
      .raddr1_i (address_vec_1),
      .re2_i    (vec_re),
      .raddr2_i (address_vec_2),
      .rdata1_o (data_vec_data_1),
      .rdata2_o (data_vec_data_2)
   );

   assign data_row_data_1 = is_row1_q ? row_rd1 : col_rd1;
   assign data_row_data_2 = is_row2_q ? row_rd2 : col_rd2;
   assign data_row_valid  = row_valid_q;
   assign data_vec_valid  = vec_valid_q;
   assign s_axis_tready   = load_state;
   assign start           = start_q;
   assign busy            = busy_q;
   assign load_error      = load_error_q;

endmodule

// File: tb/tb_tmvp_operand_store.sv
module tb_tmvp_operand_store;
   import tmvp_operand_store_pkg::*;

   localparam int N  = 32;
   localparam int DW = 8;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic          start;
   logic          res_valid;
   logic [AW-1:0] address_1, address_2;
   logic          address_1_isRow, address_2_isRow;
   logic          address_row_valid;
   logic [DW-1:0] data_row_data_1, data_row_data_2;
   logic          data_row_valid;
   logic [AW-1:0] address_vec_1, address_vec_2;
   logic          address_vec_valid;
   logic [DW-1:0] data_vec_data_1, data_vec_data_2;
   logic          data_vec_valid;
   logic          busy;
   logic          load_error;

   int total = 0;
   int bad   = 0;

   tmvp_operand_store #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk               (clk),
      .reset             (reset),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tready     (s_axis_tready),
      .s_axis_tlast      (s_axis_tlast),
      .start             (start),
      .res_valid         (res_valid),
      .address_1         (address_1),
      .address_2         (address_2),
      .address_1_isRow   (address_1_isRow),
      .address_2_isRow   (address_2_isRow),
      .address_row_valid (address_row_valid),
      .data_row_data_1   (data_row_data_1),
      .data_row_data_2   (data_row_data_2),
      .data_row_valid    (data_row_valid),
      .address_vec_1     (address_vec_1),
      .address_vec_2     (address_vec_2),
      .address_vec_valid (address_vec_valid),
      .data_vec_data_1   (data_vec_data_1),
      .data_vec_data_2   (data_vec_data_2),
      .data_vec_valid    (data_vec_valid),
      .busy              (busy),
      .load_error        (load_error)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Advance one cycle; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- drivers ----------------
   task automatic send_word(input logic [DW-1:0] d, input logic last);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      step();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic read_req(input int a1, input logic r1, input int a2, input logic r2,
                           input int v1, input int v2);
      address_1         = AW'(a1);
      address_1_isRow   = r1;
      address_2         = AW'(a2);
      address_2_isRow   = r2;
      address_vec_1     = AW'(v1);
      address_vec_2     = AW'(v2);
      address_row_valid = 1'b1;
      address_vec_valid = 1'b1;
      step();
      address_row_valid = 1'b0;
      address_vec_valid = 1'b0;
   endtask

   // Frame word k carries value k: row[i]=i, col[i]=0x20+i, vec[i]=0x40+i.
   task automatic load_frame(input bit gap);
      for (int k = 0; k < FRAME_LEN; k++) begin
         if (gap) begin
            step();
            total++;
            if (start !== 1'b0) begin
               bad++;
               $display("FAIL gap_start k=%0d start=%b expected 0", k, start);
            end
         end
         send_word(DW'(k), k == FRAME_LEN - 1);
         if (k < FRAME_LEN - 1) begin
            total++;
            if (start !== 1'b0 || s_axis_tready !== 1'b1 || busy !== 1'b0) begin
               bad++;
               $display("FAIL load_word k=%0d start=%b tready=%b busy=%b expected 0/1/0",
                        k, start, s_axis_tready, busy);
            end
         end
      end
      total++;
      if (start !== 1'b1 || busy !== 1'b1 || s_axis_tready !== 1'b0) begin
         bad++;
         $display("FAIL frame_start start=%b busy=%b tready=%b expected 1/1/0",
                  start, busy, s_axis_tready);
      end
   endtask

   task automatic run_results();
      res_valid = 1'b1;
      for (int b = 1; b <= N; b++) begin
         step();
         total++;
         if (b < N) begin
            if (busy !== 1'b1 || s_axis_tready !== 1'b0) begin
               bad++;
               $display("FAIL run_beat b=%0d busy=%b tready=%b expected 1/0", b, busy, s_axis_tready);
            end
         end else begin
            if (busy !== 1'b0 || s_axis_tready !== 1'b1) begin
               bad++;
               $display("FAIL run_end busy=%b tready=%b expected 0/1", busy, s_axis_tready);
            end
         end
      end
      res_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) step();
      total++;
      if (s_axis_tready !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || load_error !== 1'b0 ||
          data_row_valid !== 1'b0 || data_vec_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl tready=%b start=%b busy=%b lerr=%b rv=%b vv=%b expected 1/0/0/0/0/0",
                  s_axis_tready, start, busy, load_error, data_row_valid, data_vec_valid);
      end
      total++;
      if (data_row_data_1 !== 8'h00 || data_row_data_2 !== 8'h00 ||
          data_vec_data_1 !== 8'h00 || data_vec_data_2 !== 8'h00) begin
         bad++;
         $display("FAIL reset_data got %h %h %h %h expected all 00",
                  data_row_data_1, data_row_data_2, data_vec_data_1, data_vec_data_2);
      end
      reset = 1'b1;
   endtask

   task automatic test_basic_frame();
      load_frame(1'b0);
      read_req(3, 1'b1, 5, 1'b0, 31, 0);
      total++;
      if (data_row_data_1 !== 8'h03 || data_row_data_2 !== 8'h25 ||
          data_vec_data_1 !== 8'h5F || data_vec_data_2 !== 8'h40) begin
         bad++;
         $display("FAIL basic_read got %h %h %h %h expected 03 25 5f 40",
                  data_row_data_1, data_row_data_2, data_vec_data_1, data_vec_data_2);
      end
      total++;
      if (data_row_valid !== 1'b1 || data_vec_valid !== 1'b1 || start !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL basic_valid rv=%b vv=%b start=%b busy=%b expected 1/1/0/1",
                  data_row_valid, data_vec_valid, start, busy);
      end
      run_results();
   endtask

   task automatic test_load_hold();
      // Back in LOAD_ROW: requests are ignored and data outputs keep old values.
      read_req(7, 1'b1, 8, 1'b1, 9, 10);
      total++;
      if (data_row_valid !== 1'b0 || data_vec_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_valid rv=%b vv=%b expected 0/0", data_row_valid, data_vec_valid);
      end
      total++;
      if (data_row_data_1 !== 8'h03 || data_row_data_2 !== 8'h25 ||
          data_vec_data_1 !== 8'h5F || data_vec_data_2 !== 8'h40) begin
         bad++;
         $display("FAIL hold_data got %h %h %h %h expected 03 25 5f 40",
                  data_row_data_1, data_row_data_2, data_vec_data_1, data_vec_data_2);
      end
   endtask

   task automatic test_gapped_frame();
      load_frame(1'b1);
      for (int i = 0; i < N; i++) begin
         read_req(i, 1'b1, i, 1'b0, i, N - 1 - i);
         total++;
         if (data_row_data_1 !== DW'(i) || data_row_data_2 !== DW'(8'h20 + i) ||
             data_vec_data_1 !== DW'(8'h40 + i) || data_vec_data_2 !== DW'(8'h40 + N - 1 - i) ||
             data_row_valid !== 1'b1 || data_vec_valid !== 1'b1) begin
            bad++;
            $display("FAIL gap_read i=%0d got %h %h %h %h v=%b%b expected %h %h %h %h v=11",
                     i, data_row_data_1, data_row_data_2, data_vec_data_1, data_vec_data_2,
                     data_row_valid, data_vec_valid, DW'(i), DW'(8'h20 + i), DW'(8'h40 + i),
                     DW'(8'h40 + N - 1 - i));
         end
      end
      // Duplicate addresses on both ports return the same word.
      read_req(12, 1'b1, 12, 1'b1, 12, 12);
      total++;
      if (data_row_data_1 !== 8'h0C || data_row_data_2 !== 8'h0C ||
          data_vec_data_1 !== 8'h4C || data_vec_data_2 !== 8'h4C) begin
         bad++;
         $display("FAIL dup_read got %h %h %h %h expected 0c 0c 4c 4c",
                  data_row_data_1, data_row_data_2, data_vec_data_1, data_vec_data_2);
      end
      run_results();
   endtask

   task automatic test_error_early_tlast();
      for (int k = 0; k < 40; k++) send_word(DW'(k), 1'b0);
      send_word(8'd40, 1'b1);
      total++;
      if (load_error !== 1'b1 || s_axis_tready !== 1'b1 || start !== 1'b0) begin
         bad++;
         $display("FAIL early_tlast lerr=%b tready=%b start=%b expected 1/1/0",
                  load_error, s_axis_tready, start);
      end
      step();
      total++;
      if (load_error !== 1'b0) begin
         bad++;
         $display("FAIL early_tlast_pulse lerr=%b expected 0", load_error);
      end
      load_frame(1'b0);
      read_req(8, 1'b0, 0, 1'b1, 8, 0);
      total++;
      if (data_row_data_1 !== 8'h28 || data_row_data_2 !== 8'h00 ||
          data_vec_data_1 !== 8'h48 || data_vec_data_2 !== 8'h40) begin
         bad++;
         $display("FAIL after_err_read got %h %h %h %h expected 28 00 48 40",
                  data_row_data_1, data_row_data_2, data_vec_data_1, data_vec_data_2);
      end
      run_results();
   endtask

   task automatic test_error_missing_tlast();
      for (int k = 0; k < FRAME_LEN - 1; k++) send_word(DW'(k), 1'b0);
      send_word(DW'(FRAME_LEN - 1), 1'b0);
      total++;
      if (load_error !== 1'b1 || start !== 1'b0 || s_axis_tready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL missing_tlast lerr=%b start=%b tready=%b busy=%b expected 1/0/1/0",
                  load_error, start, s_axis_tready, busy);
      end
      step();
      total++;
      if (load_error !== 1'b0 || start !== 1'b0 || s_axis_tready !== 1'b1) begin
         bad++;
         $display("FAIL missing_tlast_after lerr=%b start=%b tready=%b expected 0/0/1",
                  load_error, start, s_axis_tready);
      end
   endtask

   task automatic test_reset_mid_load();
      for (int k = 0; k < 50; k++) send_word(DW'(k), 1'b0);
      reset = 1'b0;
      send_word(8'd50, 1'b0);
      reset = 1'b1;
      total++;
      if (s_axis_tready !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || load_error !== 1'b0 ||
          data_row_valid !== 1'b0 || data_vec_valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset_ctrl tready=%b start=%b busy=%b lerr=%b rv=%b vv=%b expected 1/0/0/0/0/0",
                  s_axis_tready, start, busy, load_error, data_row_valid, data_vec_valid);
      end
      total++;
      if (data_row_data_1 !== 8'h00 || data_row_data_2 !== 8'h00 ||
          data_vec_data_1 !== 8'h00 || data_vec_data_2 !== 8'h00) begin
         bad++;
         $display("FAIL midreset_data got %h %h %h %h expected all 00",
                  data_row_data_1, data_row_data_2, data_vec_data_1, data_vec_data_2);
      end
      load_frame(1'b0);
      read_req(31, 1'b1, 31, 1'b0, 15, 16);
      total++;
      if (data_row_data_1 !== 8'h1F || data_row_data_2 !== 8'h3F ||
          data_vec_data_1 !== 8'h4F || data_vec_data_2 !== 8'h50) begin
         bad++;
         $display("FAIL midreset_read got %h %h %h %h expected 1f 3f 4f 50",
                  data_row_data_1, data_row_data_2, data_vec_data_1, data_vec_data_2);
      end
      run_results();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset             = 1'b0;
      s_axis_tdata      = '0;
      s_axis_tvalid     = 1'b0;
      s_axis_tlast      = 1'b0;
      res_valid         = 1'b0;
      address_1         = '0;
      address_2         = '0;
      address_1_isRow   = 1'b0;
      address_2_isRow   = 1'b0;
      address_row_valid = 1'b0;
      address_vec_1     = '0;
      address_vec_2     = '0;
      address_vec_valid = 1'b0;

      test_reset();
      test_basic_frame();
      test_load_hold();
      test_gapped_frame();
      test_error_early_tlast();
      test_error_missing_tlast();
      test_reset_mid_load();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
